// File: rtl/ring_sequence_monitor.sv
// -----------------------------------------------------------------------------
// ring_sequence_monitor
//
// Downstream checker for an N-bit ring counter that shifts right with wrap
// (the hot bit moves from index i to i-1, and from 0 to N-1). The monitor
// locks onto a valid rotation sequence. It then tracks the token phase,
// counts completed laps and reports sequence errors. Upstream parallel
// reloads are announced through load_seen and are accepted as fresh seeds.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   en         in   1      sample qualifier (ring_in/load_seen ignored when low)
//   ring_in    in   N      ring counter parallel output
//   load_seen  in   1      upstream parallel load occurred this sample
//   clr_err    in   1      synchronous clear of err_sticky / err_cnt
//   locked     out  1      monitor is tracking a valid sequence
//   phase      out  PH_W   lowest-index hot bit of the last accepted sample
//   lap_pulse  out  1      one-cycle pulse per completed lap (0 -> N-1 wrap)
//   lap_cnt    out  LAP_W  lap count, wraps
//   err_pulse  out  1      one-cycle pulse per detected error
//   err_sticky out  1      set on any error, held until clr_err
//   err_cnt    out  ERR_W  error count, saturating
// -----------------------------------------------------------------------------
module ring_sequence_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int LAP_W    = 8,
  parameter int ERR_W    = 4,
  parameter int PH_W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     ring_in,
  input  logic             load_seen,
  input  logic             clr_err,
  output logic             locked,
  output logic [PH_W-1:0]  phase,
  output logic             lap_pulse,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int QW = $clog2(LOCK_CNT + 1);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qual_q, qual_d, qual_nxt;
  logic [N-1:0]     prev_q, prev_d, rot_prev;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             lap_pulse_q, lap_pulse_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             ring_oh, err_det;

  function automatic logic is_onehot(input logic [N-1:0] x);
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction

  // Lowest-index encoder: scanning downwards lets the lowest set bit win.
  function automatic logic [PH_W-1:0] enc_low(input logic [N-1:0] x);
    logic [PH_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (x[i]) idx = PH_W'(i);
    end
    return idx;
  endfunction

  assign ring_oh  = is_onehot(ring_in);
  assign rot_prev = {prev_q[0], prev_q[N-1:1]};

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    qual_d       = qual_q;
    qual_nxt     = qual_q;
    prev_d       = prev_q;
    phase_d      = phase_q;
    lap_pulse_d  = 1'b0;
    lap_cnt_d    = lap_cnt_q;
    err_det      = 1'b0;

    if (en) begin
      unique case (state_q)
        ACQUIRE: begin
          if (!ring_oh) begin
            qual_d = '0;
          end else begin
            prev_d  = ring_in;
            phase_d = enc_low(ring_in);
            // A seed, a reload or a broken rotation restarts qualification.
            if (qual_q == '0 || load_seen || ring_in != rot_prev)
              qual_nxt = QW'(1);
            else
              qual_nxt = qual_q + QW'(1);
            if (qual_nxt == QW'(LOCK_CNT)) begin
              state_d = TRACK;
              qual_d  = '0;
            end else begin
              qual_d = qual_nxt;
            end
          end
        end

        TRACK: begin
          if (load_seen) begin
            if (ring_oh) begin
              prev_d  = ring_in;
              phase_d = enc_low(ring_in);
            end else begin
              // A reload with an illegal seed; keep the last good token.
              err_det = 1'b1;
              state_d = ACQUIRE;
              qual_d  = '0;
            end
          end else if (ring_in == rot_prev) begin
            prev_d  = ring_in;
            phase_d = enc_low(ring_in);
            if (prev_q[0]) begin
              lap_pulse_d = 1'b1;
              lap_cnt_d   = lap_cnt_q + LAP_W'(1);
            end
          end else begin
            err_det = 1'b1;
            state_d = ACQUIRE;
            prev_d  = ring_in;
            phase_d = enc_low(ring_in);
            qual_d  = ring_oh ? QW'(1) : '0;
          end
        end

        default: state_d = ACQUIRE;
      endcase
    end

    // Error bookkeeping. clr_err is a status-register clear from system
    // logic and acts whether or not the ring is being sampled; an error
    // detected in the same cycle survives the clear as a single count.
    err_pulse_d  = err_det;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (clr_err) begin
      err_sticky_d = err_det;
      err_cnt_d    = err_det ? ERR_W'(1) : '0;
    end else if (err_det) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ACQUIRE;
      qual_q       <= '0;
      prev_q       <= '0;
      phase_q      <= '0;
      lap_pulse_q  <= 1'b0;
      lap_cnt_q    <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      qual_q       <= qual_d;
      prev_q       <= prev_d;
      phase_q      <= phase_d;
      lap_pulse_q  <= lap_pulse_d;
      lap_cnt_q    <= lap_cnt_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = (state_q == TRACK);
  assign phase      = phase_q;
  assign lap_pulse  = lap_pulse_q;
  assign lap_cnt    = lap_cnt_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// -----------------------------------------------------------------------------
// tb_ring_sequence_monitor
//
// Directed bench for ring_sequence_monitor (N=4, LOCK_CNT=2, LAP_W=8,
// ERR_W=4). The driver applies one sample per cycle and queues the
// hand-computed output state expected after the next clock edge. A separate
// monitor pops that entry just after the edge and compares every output.
// -----------------------------------------------------------------------------
module tb_ring_sequence_monitor;

  localparam int N     = 4;
  localparam int LAP_W = 8;
  localparam int ERR_W = 4;
  localparam int PH_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [N-1:0]     ring_in = '0;
  logic             load_seen = 1'b0;
  logic             clr_err = 1'b0;
  logic             locked;
  logic [PH_W-1:0]  phase;
  logic             lap_pulse;
  logic [LAP_W-1:0] lap_cnt;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;

  ring_sequence_monitor #(
    .N(N), .LOCK_CNT(2), .LAP_W(LAP_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_in),
    .load_seen(load_seen), .clr_err(clr_err), .locked(locked),
    .phase(phase), .lap_pulse(lap_pulse), .lap_cnt(lap_cnt),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    lock;
    int    ph;
    bit    lp;
    int    lc;
    bit    ep;
    bit    st;
    int    ec;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one sample and queue the outputs expected after the next edge.
  task automatic step(input bit e, input logic [N-1:0] r, input bit ld,
                      input bit cl, input bit x_lock, input int x_ph,
                      input bit x_lp, input int x_lc, input bit x_ep,
                      input bit x_st, input int x_ec, input string nm);
    exp_t x;
    @(posedge clk);
    #2;
    en = e; ring_in = r; load_seen = ld; clr_err = cl;
    x.name = nm; x.lock = x_lock; x.ph = x_ph; x.lp = x_lp; x.lc = x_lc;
    x.ep = x_ep; x.st = x_st; x.ec = x_ec;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, ".drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares the full output state against each queued entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check({x.name, ".locked"},     32'(locked),     32'(x.lock));
        check({x.name, ".phase"},      32'(phase),      32'(x.ph));
        check({x.name, ".lap_pulse"},  32'(lap_pulse),  32'(x.lp));
        check({x.name, ".lap_cnt"},    32'(lap_cnt),    32'(x.lc));
        check({x.name, ".err_pulse"},  32'(err_pulse),  32'(x.ep));
        check({x.name, ".err_sticky"}, 32'(err_sticky), 32'(x.st));
        check({x.name, ".err_cnt"},    32'(err_cnt),    32'(x.ec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec;
    // Reset state
    #3;
    check("reset.locked", 32'(locked), 32'd0);
    check("reset.phase", 32'(phase), 32'd0);
    check("reset.lap_cnt", 32'(lap_cnt), 32'd0);
    check("reset.err_cnt", 32'(err_cnt), 32'd0);
    check("reset.err_sticky", 32'(err_sticky), 32'd0);
    #4 rst = 1'b1;

    // Acquire: zeros are ignored, 1000 -> 0100 locks with phase 2.
    //   en  ring     ld cl  lock ph lp lc ep st ec
    step(1, 4'b0000, 0, 0,  0,   0, 0, 0, 0, 0, 0, "acq_zero0");
    step(1, 4'b0000, 0, 0,  0,   0, 0, 0, 0, 0, 0, "acq_zero1");
    step(1, 4'b0000, 0, 0,  0,   0, 0, 0, 0, 0, 0, "acq_zero2");
    step(1, 4'b1000, 0, 0,  0,   3, 0, 0, 0, 0, 0, "acq_seed");
    step(1, 4'b0100, 0, 0,  1,   2, 0, 0, 0, 0, 0, "acq_lock");

    // Tracking with one lap on the 0001 -> 1000 wrap.
    step(1, 4'b0010, 0, 0,  1,   1, 0, 0, 0, 0, 0, "trk_p1");
    step(1, 4'b0001, 0, 0,  1,   0, 0, 0, 0, 0, 0, "trk_p0");
    step(1, 4'b1000, 0, 0,  1,   3, 1, 1, 0, 0, 0, "trk_lap");
    step(1, 4'b0100, 0, 0,  1,   2, 0, 1, 0, 0, 0, "trk_p2");

    // Multi-hot error, then relock; sticky error stays set.
    step(1, 4'b0110, 0, 0,  0,   1, 0, 1, 1, 1, 1, "err_multi");
    step(1, 4'b0010, 0, 0,  0,   1, 0, 1, 0, 1, 1, "relock_a");
    step(1, 4'b0001, 0, 0,  1,   0, 0, 1, 0, 1, 1, "relock_b");

    // Legal reload accepted, illegal reload is an error.
    step(1, 4'b1000, 0, 0,  1,   3, 1, 2, 0, 1, 1, "trk_lap2");
    step(1, 4'b0100, 0, 0,  1,   2, 0, 2, 0, 1, 1, "trk_p2b");
    step(1, 4'b0010, 0, 0,  1,   1, 0, 2, 0, 1, 1, "trk_p1b");
    step(1, 4'b1000, 1, 0,  1,   3, 0, 2, 0, 1, 1, "load_ok");
    step(1, 4'b0100, 0, 0,  1,   2, 0, 2, 0, 1, 1, "after_load");
    step(1, 4'b0000, 1, 0,  0,   2, 0, 2, 1, 1, 2, "load_bad");

    // Relock, then alternate error/relock pairs until err_cnt saturates.
    step(1, 4'b0010, 0, 0,  0,   1, 0, 2, 0, 1, 2, "sat_seed");
    step(1, 4'b0001, 0, 0,  1,   0, 0, 2, 0, 1, 2, "sat_lock");
    for (int k = 1; k <= 15; k++) begin
      ec = (2 + k > 15) ? 15 : 2 + k;
      step(1, 4'b0001, 0, 0, 0, 0, 0, 2, 1, 1, ec, $sformatf("sat_err%0d", k));
      step(1, 4'b1000, 0, 0, 1, 3, 0, 2, 0, 1, ec, $sformatf("sat_rel%0d", k));
    end

    // clr_err with a simultaneous error leaves a count of one.
    step(1, 4'b0001, 0, 1,  0,   0, 0, 2, 1, 1, 1, "clr_with_err");
    step(1, 4'b1000, 0, 0,  1,   3, 0, 2, 0, 1, 1, "clr_relock");
    step(1, 4'b0100, 0, 1,  1,   2, 0, 2, 0, 0, 0, "clr_plain");

    // Lap pulse, then en low for 5 cycles: everything holds, pulse clears.
    step(1, 4'b0010, 0, 0,  1,   1, 0, 2, 0, 0, 0, "hold_p1");
    step(1, 4'b0001, 0, 0,  1,   0, 0, 2, 0, 0, 0, "hold_p0");
    step(1, 4'b1000, 0, 0,  1,   3, 1, 3, 0, 0, 0, "hold_lap");
    for (int k = 0; k < 5; k++)
      step(0, 4'b0110, 1, 0, 1, 3, 0, 3, 0, 0, 0, $sformatf("en_low%0d", k));
    step(1, 4'b0100, 0, 0,  1,   2, 0, 3, 0, 0, 0, "en_resume");
    drain("pre_reset");

    // Asynchronous reset between edges clears outputs immediately.
    #2;
    rst = 1'b0;
    #1;
    check("async.locked", 32'(locked), 32'd0);
    check("async.phase", 32'(phase), 32'd0);
    check("async.lap_cnt", 32'(lap_cnt), 32'd0);
    check("async.lap_pulse", 32'(lap_pulse), 32'd0);
    check("async.err_pulse", 32'(err_pulse), 32'd0);
    check("async.err_sticky", 32'(err_sticky), 32'd0);
    check("async.err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Back in ACQUIRE: two samples are needed to lock again.
    step(1, 4'b0100, 0, 0,  0,   2, 0, 0, 0, 0, 0, "post_rst_seed");
    step(1, 4'b0010, 0, 0,  1,   1, 0, 0, 0, 0, 0, "post_rst_lock");
    drain("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ring_sequence_monitor.md
Name: ring_sequence_monitor

Overview:
- Downstream checker for the team's N-bit ring counter; samples its parallel output every enabled cycle.
- Verifies that the token is one-hot and rotates correctly. The ring counter shifts right with wrap, so the hot bit moves from index i to i-1, and from 0 to N-1.
- Reports lock state, token phase, completed laps and sequence errors to system status/debug logic.
- Consumes the ring counter's load strobe so that legitimate reloads are not reported as faults.

Parameters:
- N, 4, ring width; must be ≥ 2.
- LOCK_CNT, 2, consecutive valid rotation samples needed to lock; must be ≥ 1.
- LAP_W, 8, width of the lap counter.
- ERR_W, 4, width of the error counter.
- PH_W, $clog2(N), width of the phase output; derived, do not override.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample qualifier; ring_in and load_seen are ignored when low.
- ring_in  in  N  ring counter output.
- load_seen  in  1  upstream parallel load occurred; ring_in is a fresh seed.
- clr_err  in  1  synchronous clear of err_sticky and err_cnt.
- locked  out  1  monitor is in TRACK.
- phase  out  PH_W  index of the hot bit of the last accepted sample.
- lap_pulse  out  1  one-cycle pulse per completed lap.
- lap_cnt  out  LAP_W  laps counted; wraps modulo 2^LAP_W.
- err_pulse  out  1  one-cycle pulse per detected error.
- err_sticky  out  1  set on any error, held until clr_err.
- err_cnt  out  ERR_W  error count; saturates at all-ones.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = ACQUIRE; qual_cnt = 0; prev = 0.
  - All outputs 0.
  - The upstream counter also resets to all-zero, which is not one-hot, so the monitor waits in ACQUIRE.
- Definitions:
  - onehot(x): exactly one bit set.
  - rotr(x) = {x[0], x[N-1:1]}.
- Timing:
  - All outputs are registered; an event sampled at edge k is visible after edge k.
  - Pulses last exactly one cycle.
- en = 0: state, counters and outputs hold; pulses = 0.
- ACQUIRE (locked = 0), on en:
  - Not onehot(ring_in): qual_cnt = 0.
  - onehot(ring_in), and either qual_cnt == 0, load_seen = 1, or ring_in != rotr(prev): qual_cnt = 1, prev = ring_in.
  - onehot(ring_in) and ring_in == rotr(prev): qual_cnt + 1, prev = ring_in.
  - When the updated qual_cnt reaches LOCK_CNT: go to TRACK, locked = 1, qual_cnt = 0.
  - phase tracks prev.
  - No errors and no laps are reported in ACQUIRE.
- TRACK (locked = 1), on en:
  - load_seen = 1 and onehot(ring_in): prev = ring_in, no check, no lap.
  - load_seen = 1 and not onehot(ring_in): error; go to ACQUIRE with qual_cnt = 0.
  - ring_in == rotr(prev): prev = ring_in, phase updated.
    - If prev[0] = 1 (wrap from index 0 to N-1): lap_pulse = 1 and lap_cnt + 1 (wraps).
  - Otherwise (wrong rotation, stuck, multi-hot or zero): error.
    - Go to ACQUIRE with prev = ring_in.
    - qual_cnt = 1 if onehot(ring_in), else 0.
- Error actions: err_pulse = 1; err_sticky = 1; err_cnt + 1, saturating.
- clr_err, priority below rst:
  - Clears err_sticky and err_cnt.
  - If an error is detected in the same cycle, the result is err_sticky = 1 and err_cnt = 1.
  - clr_err does not affect state, laps or phase.
- N = 2: rotr is a swap; laps are counted on the 01 → 10 transition.
- phase uses the lowest-index encoder; it is only meaningful when prev is onehot.

Test Plan:
- N = 4, LOCK_CNT = 2, en = 1. Reset, then ring_in = 0000 for 3 cycles, then 1000, 0100 → locked rises after the 0100 edge; phase = 2; err_pulse never asserted.
- Locked. Feed 0010, 0001, 1000, 0100 → one lap_pulse at the 1000 edge; lap_cnt = 1; phases 1, 0, 3, 2; no errors.
- Locked at 0100. Feed 0110 → err_pulse for one cycle; err_cnt = 1; err_sticky = 1; locked = 0. Then 0010, 0001 → relock; err_sticky stays 1.
- Locked at 0010. Assert load_seen with ring_in = 1000, then feed 0100 → no error; locked stays 1. Then load_seen with 0000 → error; locked = 0.
- Force 16+ errors with ERR_W = 4 → err_cnt saturates at 15. Pulse clr_err together with a new error → err_cnt = 1, err_sticky = 1.
- Mid-track: drop en for 5 cycles → all state holds. Then pulse rst low asynchronously between edges → outputs go to 0 immediately; state = ACQUIRE.
